// File: rtl/allocator_wavefront_pipe.sv
// allocator_wavefront_pipe: registered wavefront allocator with rotating diagonal priority.
module allocator_wavefront_pipe #(
  parameter int NUM_REQS = 4,
  parameter int NUM_RESS = NUM_REQS,
  parameter int PRIO_MODE = 1,
  localparam int N = (NUM_REQS > NUM_RESS) ? NUM_REQS : NUM_RESS,
  localparam int PW = (N > 2) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_RESS-1:0] requests [NUM_REQS],
  input  logic [NUM_RESS-1:0] res_avail,
  input  logic                req_valid,
  output logic                req_ready,
  output logic [NUM_REQS-1:0] grants [NUM_RESS],
  output logic                gnt_valid,
  input  logic                gnt_ready,
  output logic [PW-1:0]       prio_ptr
);
  logic [N-1:0]        req_m [N];
  logic [N-1:0]        gnt_m [N];
  logic [N-1:0]        row_used, col_used;
  logic                found, accept, gnt_valid_q;
  logic [PW-1:0]       first_d, prio_ptr_d, prio_ptr_q;
  logic [NUM_REQS-1:0] grants_d [NUM_RESS];
  logic [NUM_REQS-1:0] grants_q [NUM_RESS];
  int                  j, k;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    return (x == PW'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  // Cells of one diagonal never share a row or column, so marking used rows/columns
  // immediately is equivalent to updating them after the whole diagonal.
  always_comb begin
    req_m = '{default: '0};
    gnt_m = '{default: '0};
    grants_d = '{default: '0};
    row_used = '0;
    col_used = '0;
    found = 1'b0;
    first_d = prio_ptr_q;
    j = 0;
    k = 0;
    for (int i = 0; i < NUM_REQS; i++) req_m[i][NUM_RESS-1:0] = requests[i] & res_avail;
    for (int o = 0; o < N; o++) begin
      k = (int'(prio_ptr_q) + o) % N;
      for (int i = 0; i < N; i++) begin
        j = (k + N - i) % N;
        if (req_m[i][j] && !row_used[i] && !col_used[j]) begin
          gnt_m[i][j] = 1'b1;
          row_used[i] = 1'b1;
          col_used[j] = 1'b1;
          first_d = found ? first_d : PW'(k);
          found = 1'b1;
        end
      end
    end
    for (int r = 0; r < NUM_RESS; r++)
      for (int i = 0; i < NUM_REQS; i++) grants_d[r][i] = gnt_m[i][r];
    prio_ptr_d = (PRIO_MODE == 0) ? wrap_inc(prio_ptr_q) : found ? wrap_inc(first_d) : prio_ptr_q;
  end

  assign req_ready = !gnt_valid_q | gnt_ready;
  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grants_q <= '{default: '0};
      gnt_valid_q <= 1'b0;
      prio_ptr_q <= '0;
    end else if (accept) begin
      grants_q <= grants_d;
      gnt_valid_q <= 1'b1;
      prio_ptr_q <= prio_ptr_d;
    end else if (gnt_ready) begin
      grants_q <= '{default: '0};
      gnt_valid_q <= 1'b0;
    end
  end

  assign grants = grants_q;
  assign gnt_valid = gnt_valid_q;
  assign prio_ptr = prio_ptr_q;
endmodule

// File: tb/tb_allocator_wavefront_pipe.sv
// tb_allocator_wavefront_pipe: directed checks on 4x4 / 3x5 / 3x3 allocators plus randomized legality sweep.
module tb_allocator_wavefront_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0]  a_req [4];
  logic [3:0]  a_av, a_g [4];
  logic        a_rv, a_rr, a_gv, a_gr;
  logic [1:0]  a_ptr;
  logic [15:0] a_flat;
  assign a_flat = {a_g[3], a_g[2], a_g[1], a_g[0]};

  logic [4:0]  b_req [3];
  logic [4:0]  b_av;
  logic [2:0]  b_g [5];
  logic        b_rv, b_rr, b_gv, b_gr;
  logic [2:0]  b_ptr;
  logic [14:0] b_flat;
  assign b_flat = {b_g[4], b_g[3], b_g[2], b_g[1], b_g[0]};

  logic [2:0]  c_req [3];
  logic [2:0]  c_av, c_g [3];
  logic        c_rv, c_rr, c_gv, c_gr;
  logic [1:0]  c_ptr;
  logic [8:0]  c_flat;
  assign c_flat = {c_g[2], c_g[1], c_g[0]};

  allocator_wavefront_pipe #(.NUM_REQS(4), .PRIO_MODE(1)) u_a (
    .clk(clk), .reset(reset), .requests(a_req), .res_avail(a_av), .req_valid(a_rv),
    .req_ready(a_rr), .grants(a_g), .gnt_valid(a_gv), .gnt_ready(a_gr), .prio_ptr(a_ptr));

  allocator_wavefront_pipe #(.NUM_REQS(3), .NUM_RESS(5), .PRIO_MODE(1)) u_b (
    .clk(clk), .reset(reset), .requests(b_req), .res_avail(b_av), .req_valid(b_rv),
    .req_ready(b_rr), .grants(b_g), .gnt_valid(b_gv), .gnt_ready(b_gr), .prio_ptr(b_ptr));

  allocator_wavefront_pipe #(.NUM_REQS(3), .PRIO_MODE(0)) u_c (
    .clk(clk), .reset(reset), .requests(c_req), .res_avail(c_av), .req_valid(c_rv),
    .req_ready(c_rr), .grants(c_g), .gnt_valid(c_gv), .gnt_ready(c_gr), .prio_ptr(c_ptr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] rq_s [3];
  logic [4:0] av_s;
  int         rowcnt [3];
  bit         legal, maximal;
  logic [1:0] c_exp [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

  initial begin
    a_req = '{default: '0}; a_av = 4'hf; a_rv = 0; a_gr = 0;
    b_req = '{default: '0}; b_av = 5'h1f; b_rv = 0; b_gr = 0;
    c_req = '{default: '0}; c_av = 3'h7; c_rv = 0; c_gr = 0;
    #3;
    chk("rst_gv", a_gv, 0);
    chk("rst_rr", a_rr, 1);
    chk("rst_grants", a_flat, 0);
    chk("rst_ptr", a_ptr, 0);
    #4 reset = 1;
    tick;
    // two requestors contend for res2; diagonal 2 (req0) beats 3 (req1) from ptr 0
    a_req = '{4'b0100, 4'b0100, 4'b0000, 4'b0000}; a_rv = 1; a_gr = 1;
    tick;
    chk("contend_p0_grants", a_flat, 16'h0100);
    chk("contend_p0_ptr", a_ptr, 3);
    chk("contend_p0_gv", a_gv, 1);
    tick;
    chk("contend_p3_grants", a_flat, 16'h0200);
    chk("contend_p3_ptr", a_ptr, 0);
    a_req = '{default: 4'b1111};
    tick;
    chk("full_diag0_grants", a_flat, 16'h2481);
    chk("full_diag0_ptr", a_ptr, 1);
    a_av = 4'b0101;
    tick;
    chk("avail_mask_grants", a_flat, 16'h0802);
    chk("avail_mask_ptr", a_ptr, 2);
    a_av = 4'hf; a_gr = 0;
    #1 chk("stall_rr", a_rr, 0);
    for (int s = 0; s < 3; s++) begin
      tick;
      chk("stall_grants", a_flat, 16'h0802);
      chk("stall_ptr", a_ptr, 2);
      chk("stall_gv", a_gv, 1);
    end
    a_gr = 1;
    tick;
    chk("release_grants", a_flat, 16'h8124);
    chk("release_ptr", a_ptr, 3);
    chk("release_gv", a_gv, 1);
    a_rv = 0;
    tick;
    chk("drain_gv", a_gv, 0);
    chk("drain_grants", a_flat, 0);
    chk("drain_ptr", a_ptr, 3);
    a_rv = 1; a_req = '{default: '0};
    tick;
    chk("empty_gv", a_gv, 1);
    chk("empty_grants", a_flat, 0);
    chk("empty_ptr", a_ptr, 3);
    #2 reset = 0;
    #1;
    chk("midrst_gv", a_gv, 0);
    chk("midrst_grants", a_flat, 0);
    chk("midrst_ptr", a_ptr, 0);
    chk("midrst_rr", a_rr, 1);
    #2 reset = 1;
    a_req = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    tick;
    chk("post_rst_grants", a_flat, 16'h0100);
    chk("post_rst_ptr", a_ptr, 3);
    a_rv = 0;

    c_rv = 1; c_gr = 1;
    for (int s = 0; s < 5; s++) begin
      tick;
      chk("mode0_ptr", c_ptr, c_exp[s]);
      chk("mode0_grants", c_flat, 0);
      chk("mode0_gv", c_gv, 1);
    end
    c_rv = 0;

    b_req = '{default: 5'b11111}; b_av = 5'b00110; b_rv = 1; b_gr = 1;
    tick;
    chk("pad_grants", b_flat, 15'h0088);
    chk("pad_ptr", b_ptr, 2);
    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < 3; i++) begin
        rq_s[i] = 5'($urandom);
        b_req[i] = rq_s[i];
      end
      av_s = 5'($urandom);
      b_av = av_s;
      tick;
      legal = 1; maximal = 1;
      rowcnt = '{default: 0};
      for (int r = 0; r < 5; r++) begin
        if ($countones(b_g[r]) > 1) legal = 0;
        for (int i = 0; i < 3; i++)
          if (b_g[r][i]) begin
            rowcnt[i]++;
            if (!(rq_s[i][r] && av_s[r])) legal = 0;
          end
      end
      for (int i = 0; i < 3; i++) begin
        if (rowcnt[i] > 1) legal = 0;
        for (int r = 0; r < 5; r++)
          if (rq_s[i][r] && av_s[r] && rowcnt[i] == 0 && b_g[r] == 0) maximal = 0;
      end
      chk("rand_legal", {31'b0, legal}, 1);
      chk("rand_maximal", {31'b0, maximal}, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/allocator_wavefront_pipe.md
ALLOCATOR_WAVEFRONT_PIPE -- requirements
Module: allocator_wavefront_pipe

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of requestors (>=2).
REQ-002 SHALL have parameter NUM_RESS, default NUM_REQS, number of resources (>=2, may differ from NUM_REQS).
REQ-003 SHALL have parameter PRIO_MODE, default 1: 0 = diagonal pointer +1 per accepted allocation; 1 = pointer moves past first granted diagonal.
REQ-004 SHALL derive localparam N = max(NUM_REQS, NUM_RESS) and localparam PW = max(1, clog2(N)).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 requests  input  [NUM_RESS] x NUM_REQS (unpacked by requestor)  per-requestor request vector; bit j requests resource j.
REQ-008 res_avail  input  NUM_RESS  resource j grantable only when bit j = 1.
REQ-009 req_valid  input  1  requests/res_avail valid this cycle.
REQ-010 req_ready  output  1  block accepts the current request set.
REQ-011 grants  output  [NUM_REQS] x NUM_RESS (unpacked by resource)  per-resource one-hot requestor grant, registered.
REQ-012 gnt_valid  output  1  grants holds an unconsumed allocation.
REQ-013 gnt_ready  input  1  consumer accepts grants.
REQ-014 prio_ptr  output  PW  current high-priority diagonal, for debug/coverage.

Function
REQ-015 SHALL pad the request matrix to N x N with zeros; padded rows/columns never receive grants.
REQ-016 Cell (i,j) (requestor i, resource j) SHALL belong to diagonal (i+j) mod N; diagonal prio_ptr has highest priority, then (prio_ptr+1) mod N, ... wrapping.
REQ-017 Allocation SHALL be combinational, wavefront order: diagonal k granted where request=1, res_avail[j]=1, row i and column j not granted on an earlier diagonal this pass.
REQ-018 Result SHALL be a legal matching: <=1 grant per requestor, <=1 grant per resource.
REQ-019 Result SHALL be maximal: no eligible request left with both its row and column ungranted.
REQ-020 req_ready SHALL equal (!gnt_valid | gnt_ready); accept = req_valid & req_ready.
REQ-021 On accept, grants SHALL load the allocation and gnt_valid SHALL set next cycle: latency exactly 1 cycle, even if allocation is all-zero.
REQ-022 On gnt_valid & gnt_ready & !accept, gnt_valid SHALL clear; grants SHALL clear to 0.
REQ-023 While gnt_valid & !gnt_ready, grants, gnt_valid and prio_ptr SHALL hold; new requests are not sampled.
REQ-024 Simultaneous consume and accept SHALL replace grants in the same edge (full throughput, 1 allocation/cycle).
REQ-025 prio_ptr SHALL update only on accept.
REQ-026 PRIO_MODE 0: prio_ptr <= (prio_ptr+1) mod N on every accept.
REQ-027 PRIO_MODE 1: let d = first diagonal, scanning from prio_ptr circularly, containing a grant; prio_ptr <= (d+1) mod N; unchanged if no grant.
REQ-028 Pointer arithmetic SHALL wrap at N, not 2^PW (e.g. N=3: 2 -> 0).
REQ-029 Request bits referencing res_avail=0 resources SHALL neither be granted nor block other cells.

Reset
REQ-030 While reset=0: gnt_valid=0, grants all 0, prio_ptr=0, req_ready=1, irrespective of clk.
REQ-031 Reset asserted mid-transfer SHALL discard the pending allocation immediately; first accept after deassertion uses prio_ptr=0.

Verification
REQ-032 4x4, PRIO_MODE 1, prio_ptr=0, all requests=4'b1111, res_avail=1111, gnt_ready=1 -> next cycle grants diagonal 0 (req0->res0, req1->res3, req2->res2, req3->res1), prio_ptr=1.
REQ-033 4x4, req0 and req1 both request only res2, prio_ptr=0 -> req0 granted (diagonal 2 before 3); with prio_ptr=3 -> req1 granted.
REQ-034 3x5 (N=5), requests all 1s, res_avail=5'b00110 -> exactly two grants, only on res1/res2, no grant to padded row; 1000 random cycles: matching legal and maximal every cycle.
REQ-035 gnt_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, grants and prio_ptr stable; gnt_ready=1 -> next set accepted same edge, gnt_valid stays 1.
REQ-036 PRIO_MODE 0, N=3, 5 accepts with all-zero requests -> prio_ptr 0,1,2,0,1,2; grants all 0, gnt_valid=1 each cycle.
REQ-037 reset pulled low between edges while gnt_valid=1 -> gnt_valid=0 and grants=0 before next clk edge; prio_ptr=0.
